regbank_banco: RTL and testbench

REGBANK_BANCO -- requirements
Module: regbank_banco

---
 rtl/regbank_pkg.sv | 20 ++
 rtl/regbank_scoreboard.sv | 93 +++++++++
 rtl/regbank_banco.sv | 119 +++++++++++
 tb/tb_regbank_banco.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank.
// Holds the default geometry of the bank, the index of the hard-wired zero
// register, and a helper that decides whether an index is a real writable
// register (nonzero and inside the bank).
package regbank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;

    // Register 0 is constant zero: it ignores writes and reservations.
    localparam int unsigned ZERO_REG = 0;

    // True when the index names a register that can hold data or be busy.
    function automatic logic is_writable_index(input int unsigned index,
                                               input int unsigned num_regs);
        return (index != ZERO_REG) && (index < num_regs);
    endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard for the register bank.
// One busy bit per register. A reservation marks a destination pending, an
// accepted write-back clears it, and a reservation arriving in the same cycle
// as the write-back to the same register wins. The stall output tells the
// requester that a source operand is still pending and the read must be retried.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset (clears every busy bit)
//   reserve_valid reservation strobe, reserve_addr is the destination index
//   write_enable  write-back strobe, rd_addr is the destination index
//   read_enable   read request for rs_addr/rt_addr
//   stall         combinational: read requested and a source is pending
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_addr,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              stall
);

    logic [NUM_REGS-1:0] busy;
    logic                reserve_ok;
    logic                write_ok;
    logic                rs_busy;
    logic                rt_busy;

    assign reserve_ok = reserve_valid && is_writable_index(32'(reserve_addr), NUM_REGS);
    assign write_ok   = write_enable  && is_writable_index(32'(rd_addr), NUM_REGS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                // The zero register can never be pending.
                assign busy[gi] = 1'b0;
            end else begin : g_bit
                logic busy_reg;
                logic busy_next;

                always_comb begin
                    busy_next = busy_reg;
                    if (write_ok && (rd_addr == ADDR_W'(gi))) begin
                        busy_next = 1'b0;
                    end
                    // Evaluated after the clear so a new reservation wins.
                    if (reserve_ok && (reserve_addr == ADDR_W'(gi))) begin
                        busy_next = 1'b1;
                    end
                end

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        busy_reg <= 1'b0;
                    end else begin
                        busy_reg <= busy_next;
                    end
                end

                assign busy[gi] = busy_reg;
            end
        end
    endgenerate

    // A pending operand being written back this very cycle is not a hazard:
    // the bank forwards the write-back data to the read.
    always_comb begin
        rs_busy = 1'b0;
        if (is_writable_index(32'(rs_addr), NUM_REGS)) begin
            rs_busy = busy[rs_addr] && !(write_enable && (rd_addr == rs_addr));
        end
    end

    always_comb begin
        rt_busy = 1'b0;
        if (is_writable_index(32'(rt_addr), NUM_REGS)) begin
            rt_busy = busy[rt_addr] && !(write_enable && (rd_addr == rt_addr));
        end
    end

    assign stall = read_enable && (rs_busy || rt_busy);

endmodule

// File: rtl/regbank_banco.sv
// Two-read, one-write register bank with a busy-bit scoreboard.
// Reads are registered (one-cycle latency) and qualified by read_valid. A read
// is refused (stall) while a source register is reserved and not yet written
// back. Write-back data is forwarded to a read accepted in the same cycle.
// Register 0 reads zero; out-of-range indices read zero and are never written.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   read_enable, rs_addr, rt_addr   read request and source indices
//   rs_data, rt_data, read_valid    registered read results and their strobe
//   write_enable, rd_addr, rd_data  write-back strobe, index and value
//   reserve_valid, reserve_addr     mark a destination as pending
//   stall                           read must be retried (operand pending)
module regbank_banco
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              reserve_valid,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              stall,
    output logic              read_valid
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic [DATA_W-1:0] rs_data_reg;
    logic [DATA_W-1:0] rs_data_next;
    logic [DATA_W-1:0] rt_data_reg;
    logic [DATA_W-1:0] rt_data_next;
    logic              read_valid_reg;
    logic              read_valid_next;
    logic              write_ok;
    logic              read_accept;

    regbank_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clock         (clock),
        .reset_n       (reset_n),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .write_enable  (write_enable),
        .rd_addr       (rd_addr),
        .read_enable   (read_enable),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .stall         (stall)
    );

    assign write_ok    = write_enable && is_writable_index(32'(rd_addr), NUM_REGS);
    assign read_accept = read_enable && !stall;

    // Register 0 is reset to zero and never selected by write_ok, so it stays
    // zero; reads of it are forced to zero anyway.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (write_ok) begin
            regs_reg[rd_addr] <= rd_data;
        end
    end

    // Source operand value including forwarding of this cycle's write-back.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = '0;
        if (is_writable_index(32'(addr), NUM_REGS)) begin
            if (write_ok && (rd_addr == addr)) begin
                value = rd_data;
            end else begin
                value = regs_reg[addr];
            end
        end
        return value;
    endfunction

    always_comb begin
        rs_data_next    = rs_data_reg;
        rt_data_next    = rt_data_reg;
        read_valid_next = 1'b0;
        if (read_accept) begin
            rs_data_next    = read_value(rs_addr);
            rt_data_next    = read_value(rt_addr);
            read_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_data_reg    <= '0;
            rt_data_reg    <= '0;
            read_valid_reg <= 1'b0;
        end else begin
            rs_data_reg    <= rs_data_next;
            rt_data_reg    <= rt_data_next;
            read_valid_reg <= read_valid_next;
        end
    end

    assign rs_data    = rs_data_reg;
    assign rt_data    = rt_data_reg;
    assign read_valid = read_valid_reg;

endmodule

// File: tb/tb_regbank_banco.sv
module tb_regbank_banco;

    logic        clock;
    logic        reset_n;
    logic        read_enable;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        write_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        stall;
    logic        read_valid;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_rs;
    logic [31:0] last_rt;
    int          checks;
    int          errors;

    regbank_banco dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .read_enable   (read_enable),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .write_enable  (write_enable),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .stall         (stall),
        .read_valid    (read_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        read_enable   = 1'b0;
        rs_addr       = '0;
        rt_addr       = '0;
        write_enable  = 1'b0;
        rd_addr       = '0;
        rd_data       = '0;
        reserve_valid = 1'b0;
        reserve_addr  = '0;
    endtask

    // One clock cycle of stimulus. Called just after a rising edge.
    task automatic step(input string name,
                        input logic re, input logic [4:0] rs, input logic [4:0] rt,
                        input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra,
                        input logic exp_stall,
                        input logic [31:0] exp_rs, input logic [31:0] exp_rt);
        exp_t e;
        read_enable   = re;
        rs_addr       = rs;
        rt_addr       = rt;
        write_enable  = we;
        rd_addr       = rd;
        rd_data       = wd;
        reserve_valid = rv;
        reserve_addr  = ra;
        @(negedge clock);
        check({name, " stall"}, 32'(stall), 32'(exp_stall));
        $display("step %s: re=%0b rs=%0d rt=%0d we=%0b rd=%0d wd=0x%08h rv=%0b ra=%0d stall=%0b",
                 name, re, rs, rt, we, rd, wd, rv, ra, stall);
        if (re && !exp_stall) begin
            e.rs   = exp_rs;
            e.rt   = exp_rt;
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    // Monitor: compare every presented read result against the queue; when no
    // read result is presented the outputs must hold their last values.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (read_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected read_valid: got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    $display("read %s: rs_data=0x%08h rt_data=0x%08h", e.name, rs_data, rt_data);
                    check({e.name, " rs_data"}, rs_data, e.rs);
                    check({e.name, " rt_data"}, rt_data, e.rt);
                    last_rs = e.rs;
                    last_rt = e.rt;
                end
            end else if (reset_n === 1'b1) begin
                check("hold rs_data", rs_data, last_rs);
                check("hold rt_data", rt_data, last_rt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        last_rs = '0;
        last_rt = '0;
        idle_inputs();
        reset_n = 1'b0;
        #2;
        read_enable = 1'b1;
        #1;
        check("reset rs_data", rs_data, 32'h0);
        check("reset rt_data", rt_data, 32'h0);
        check("reset read_valid", 32'(read_valid), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        idle_inputs();
        #4;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        //    name           re rs  rt  we rd  wd            rv ra  stall rs_exp        rt_exp
        step("wr5",          0, 0,  0,  1, 5,  32'hF305218F, 0, 0,  0, 0, 0);
        step("rd5",          1, 5,  0,  0, 0,  0,            0, 0,  0, 32'hF305218F, 32'h0);
        step("bypass7",      1, 7,  5,  1, 7,  32'h12345678, 0, 0,  0, 32'h12345678, 32'hF305218F);
        step("rsv9",         0, 0,  0,  0, 0,  0,            1, 9,  0, 0, 0);
        step("rd9_stall",    1, 9,  0,  0, 0,  0,            0, 0,  1, 0, 0);
        step("rd9_retry",    1, 9,  0,  1, 9,  32'hA5A5A5A5, 0, 0,  0, 32'hA5A5A5A5, 32'h0);
        step("rd9_both",     1, 9,  9,  0, 0,  0,            0, 0,  0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        step("wr0_rsv0",     0, 0,  0,  1, 0,  32'hFFFFFFFF, 1, 0,  0, 0, 0);
        step("rd0",          1, 0,  0,  0, 0,  0,            0, 0,  0, 32'h0, 32'h0);
        step("collide3",     0, 0,  0,  1, 3,  32'h11,       1, 3,  0, 0, 0);
        step("noread3",      0, 3,  3,  0, 0,  0,            0, 0,  0, 0, 0);
        step("rd3_rs_stall", 1, 3,  5,  0, 0,  0,            0, 0,  1, 0, 0);
        step("rd3_rt_stall", 1, 0,  3,  0, 0,  0,            0, 0,  1, 0, 0);
        step("rd3_bypass",   1, 3,  7,  1, 3,  32'h22,       0, 0,  0, 32'h22, 32'h12345678);
        step("rd3_clear",    1, 3,  0,  0, 0,  0,            0, 0,  0, 32'h22, 32'h0);
        step("wr4_rsv6",     0, 0,  0,  1, 4,  32'h55,       1, 6,  0, 0, 0);
        step("rd6_stall",    1, 6,  0,  0, 0,  0,            0, 0,  1, 0, 0);
        step("rd4",          1, 4,  5,  0, 0,  0,            0, 0,  0, 32'h55, 32'hF305218F);

        // Reset pulse between edges, with a read and a write being requested.
        read_enable  = 1'b1;
        rs_addr      = 5'd6;
        rt_addr      = 5'd4;
        write_enable = 1'b1;
        rd_addr      = 5'd4;
        rd_data      = 32'h99;
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset rs_data", rs_data, 32'h0);
        check("midreset rt_data", rt_data, 32'h0);
        check("midreset read_valid", 32'(read_valid), 32'h0);
        check("midreset stall", 32'(stall), 32'h0);
        $display("step midreset: rs_data=0x%08h rt_data=0x%08h read_valid=%0b stall=%0b",
                 rs_data, rt_data, read_valid, stall);
        exp_q.delete();
        last_rs = '0;
        last_rt = '0;
        idle_inputs();
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        step("post_rd4_6",   1, 4,  6,  0, 0,  0,            0, 0,  0, 32'h0, 32'h0);
        step("post_rd5_7",   1, 5,  7,  0, 0,  0,            0, 0,  0, 32'h0, 32'h0);

        repeat (3) @(posedge clock);
        #1;
        check("queue drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
